histogram_median_locator: RTL and testbench

- Consumes one axis of the projection-histogram stream (x or y) produced by the histogram stage and finds the median bin index: the position splitting the foreground-pixel mass in half.
- Two instances sit directly downstream of the histogram stage, one on the x stream (240 bins) and one on the y stream (180 bins).
- The block buffers the whole stream, then runs a cumulative-sum scan over the buffer.

---
 rtl/histogram_median_locator.sv | 176 +++++++++++++++++
 tb/tb_histogram_median_locator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_median_locator.sv
// Median-bin locator for one projection-histogram axis: buffers a frame of bins,
// then walks the cumulative mass until it reaches half of the frame total.
module histogram_median_locator #(
   parameter int NUM_BINS    = 240,
   parameter int BIN_WIDTH   = 8,
   parameter int INDEX_WIDTH = 8,
   parameter int SUM_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [BIN_WIDTH-1:0]   binIn,
   input  logic                   binValid,
   output logic                   busy,
   output logic [INDEX_WIDTH-1:0] medianIndex,
   output logic [SUM_WIDTH-1:0]   totalCount,
   output logic                   emptyFrame,
   output logic                   medianValid,
   output logic                   dropError,
   output logic [1:0]             dbgState
);

   // Handshake: a bin transfers on any clk edge where binValid is high and busy is low.
   // There is no backpressure; a bin presented while busy is lost and flagged in dropError.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_SCAN = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_BINS - 1);

   state_t                 r_state;
   logic [INDEX_WIDTH-1:0] r_wr_cnt;
   logic [SUM_WIDTH-1:0]   r_total;
   logic [INDEX_WIDTH-1:0] r_rd_addr;
   logic                   r_rd_issue;
   logic                   r_rd_vld;
   logic [INDEX_WIDTH-1:0] r_rd_idx;
   logic [BIN_WIDTH-1:0]   r_rd_data;
   logic [SUM_WIDTH-1:0]   r_cum;
   logic                   r_cum_vld;
   logic [INDEX_WIDTH-1:0] r_cum_idx;
   logic                   r_busy;
   logic [INDEX_WIDTH-1:0] r_median;
   logic [SUM_WIDTH-1:0]   r_total_out;
   logic                   r_empty;
   logic                   r_median_valid;
   logic                   r_drop;

   logic [BIN_WIDTH-1:0]   r_mem [NUM_BINS];

   logic                   w_wr_en;
   logic [INDEX_WIDTH-1:0] w_wr_addr;
   logic                   w_rd_en;
   logic                   w_hit;

   assign w_wr_en   = binValid && ((r_state == S_IDLE) || (r_state == S_LOAD));
   assign w_wr_addr = (r_state == S_IDLE) ? '0 : r_wr_cnt;
   assign w_rd_en   = (r_state == S_SCAN) && r_rd_issue;

   // Compare at SUM_WIDTH+1 bits so doubling the running sum never wraps.
   // A zero total resolves here on the first returned bin, giving median 0.
   assign w_hit = (r_state == S_SCAN) && r_cum_vld &&
                  ({r_cum, 1'b0} >= {1'b0, r_total});

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_wr_addr] <= binIn;
      end
      if (w_rd_en) begin
         r_rd_data <= r_mem[r_rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_wr_cnt       <= '0;
         r_total        <= '0;
         r_rd_addr      <= '0;
         r_rd_issue     <= 1'b0;
         r_rd_vld       <= 1'b0;
         r_rd_idx       <= '0;
         r_cum          <= '0;
         r_cum_vld      <= 1'b0;
         r_cum_idx      <= '0;
         r_busy         <= 1'b0;
         r_median       <= '0;
         r_total_out    <= '0;
         r_empty        <= 1'b0;
         r_median_valid <= 1'b0;
         r_drop         <= 1'b0;
      end else begin
         r_median_valid <= 1'b0;
         if (binValid && r_busy) begin
            r_drop <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (binValid) begin
                  r_total    <= SUM_WIDTH'(binIn);
                  r_wr_cnt   <= INDEX_WIDTH'(1);
                  r_rd_addr  <= '0;
                  r_rd_issue <= 1'b1;
                  r_rd_vld   <= 1'b0;
                  r_cum      <= '0;
                  r_cum_vld  <= 1'b0;
                  if (NUM_BINS == 1) begin
                     r_state <= S_SCAN;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= S_LOAD;
                  end
               end
            end

            S_LOAD: begin
               if (binValid) begin
                  r_total  <= r_total + SUM_WIDTH'(binIn);
                  r_wr_cnt <= r_wr_cnt + INDEX_WIDTH'(1);
                  if (r_wr_cnt == LAST_IDX) begin
                     r_state <= S_SCAN;
                     r_busy  <= 1'b1;
                  end
               end
            end

            S_SCAN: begin
               // Three-stage walk: issue address, memory returns, accumulate; compare on the sum.
               if (w_rd_en) begin
                  r_rd_idx  <= r_rd_addr;
                  r_rd_addr <= r_rd_addr + INDEX_WIDTH'(1);
                  if (r_rd_addr == LAST_IDX) begin
                     r_rd_issue <= 1'b0;
                  end
               end
               r_rd_vld <= w_rd_en;
               if (r_rd_vld) begin
                  r_cum     <= r_cum + SUM_WIDTH'(r_rd_data);
                  r_cum_idx <= r_rd_idx;
               end
               r_cum_vld <= r_rd_vld;
               if (w_hit) begin
                  r_state        <= S_DONE;
                  r_median       <= r_cum_idx;
                  r_total_out    <= r_total;
                  r_empty        <= (r_total == '0);
                  r_median_valid <= 1'b1;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign medianIndex = r_median;
   assign totalCount  = r_total_out;
   assign emptyFrame  = r_empty;
   assign medianValid = r_median_valid;
   assign dropError   = r_drop;
   assign dbgState    = r_state;

endmodule

// File: tb/tb_histogram_median_locator.sv
// Directed bench for histogram_median_locator: a 240-bin and a 180-bin instance
// driven from a vector table plus hand-written drop and mid-frame reset sequences.
module tb_histogram_median_locator;

   logic        clk;
   logic        reset;

   logic [7:0]  bin_a;
   logic        vld_a;
   logic        busy_a;
   logic [7:0]  med_a;
   logic [15:0] tot_a;
   logic        emp_a;
   logic        mv_a;
   logic        drop_a;
   logic [1:0]  st_a;

   logic [7:0]  bin_b;
   logic        vld_b;
   logic        busy_b;
   logic [7:0]  med_b;
   logic [15:0] tot_b;
   logic        emp_b;
   logic        mv_b;
   logic        drop_b;
   logic [1:0]  st_b;

   int n_checks;
   int n_errors;

   histogram_median_locator #(
      .NUM_BINS(240), .BIN_WIDTH(8), .INDEX_WIDTH(8), .SUM_WIDTH(16)
   ) dut_x (
      .clk(clk), .reset(reset), .binIn(bin_a), .binValid(vld_a),
      .busy(busy_a), .medianIndex(med_a), .totalCount(tot_a),
      .emptyFrame(emp_a), .medianValid(mv_a), .dropError(drop_a),
      .dbgState(st_a)
   );

   histogram_median_locator #(
      .NUM_BINS(180), .BIN_WIDTH(8), .INDEX_WIDTH(8), .SUM_WIDTH(16)
   ) dut_y (
      .clk(clk), .reset(reset), .binIn(bin_b), .binValid(vld_b),
      .busy(busy_b), .medianIndex(med_b), .totalCount(tot_b),
      .emptyFrame(emp_b), .medianValid(mv_b), .dropError(drop_b),
      .dbgState(st_b)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int sel;       // 0: 240-bin instance, 1: 180-bin instance
      int fill;
      int s0_idx;
      int s0_val;
      int s1_idx;
      int s1_val;
      bit gaps;
      int exp_med;
      int exp_tot;
      bit exp_emp;
      int lat_min;
      int lat_max;
   } vec_t;

   vec_t vecs[8];

   function automatic vec_t mk(input int sel, input int fill, input int s0i, input int s0v,
                               input int s1i, input int s1v, input bit gaps, input int em,
                               input int et, input bit ee, input int lmin, input int lmax);
      vec_t v;
      v.sel = sel; v.fill = fill; v.s0_idx = s0i; v.s0_val = s0v;
      v.s1_idx = s1i; v.s1_val = s1v; v.gaps = gaps; v.exp_med = em;
      v.exp_tot = et; v.exp_emp = ee; v.lat_min = lmin; v.lat_max = lmax;
      return v;
   endfunction

   function automatic logic [7:0] bin_val(input vec_t v, input int i);
      if (i == v.s0_idx) return 8'(v.s0_val);
      if (i == v.s1_idx) return 8'(v.s1_val);
      return 8'(v.fill);
   endfunction

   function automatic int nbins(input int sel);
      return (sel != 0) ? 180 : 240;
   endfunction

   function automatic logic [31:0] get_med(input int sel);
      return (sel != 0) ? 32'(med_b) : 32'(med_a);
   endfunction
   function automatic logic [31:0] get_tot(input int sel);
      return (sel != 0) ? 32'(tot_b) : 32'(tot_a);
   endfunction
   function automatic logic get_emp(input int sel);
      return (sel != 0) ? emp_b : emp_a;
   endfunction
   function automatic logic get_mv(input int sel);
      return (sel != 0) ? mv_b : mv_a;
   endfunction
   function automatic logic get_busy(input int sel);
      return (sel != 0) ? busy_b : busy_a;
   endfunction
   function automatic logic get_drop(input int sel);
      return (sel != 0) ? drop_b : drop_a;
   endfunction

   // scoreboard helpers
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // driver tasks
   task automatic drive(input int sel, input logic v, input logic [7:0] d);
      if (sel != 0) begin
         vld_b = v; bin_b = d;
      end else begin
         vld_a = v; bin_a = d;
      end
   endtask

   task automatic send_frame(input vec_t v, input int count, input int extra);
      int g;
      for (int i = 0; i < count; i++) begin
         @(negedge clk);
         drive(v.sel, 1'b1, bin_val(v, i));
         if (v.gaps && i < count - 1) begin
            g = $urandom_range(1, 3);
            repeat (g) begin
               @(negedge clk);
               drive(v.sel, 1'b0, 8'h00);
            end
         end
      end
      repeat (extra) begin
         @(negedge clk);
         drive(v.sel, 1'b1, 8'hAA);
      end
      @(negedge clk);
      drive(v.sel, 1'b0, 8'h00);
   endtask

   // Latency n: medianValid first seen just after the n-th edge following the last-bin edge.
   task automatic wait_result(input int sel, input int extra, output bit found, output int lat);
      found = 1'b0;
      lat   = 0;
      for (int c = extra + 1; c <= extra + 400 && !found; c++) begin
         @(posedge clk); #1;
         if (get_mv(sel)) begin
            found = 1'b1;
            lat   = c;
         end
      end
   endtask

   task automatic run_vector(input vec_t v, input int extra, input int id);
      bit found;
      int lat;
      send_frame(v, nbins(v.sel), extra);
      wait_result(v.sel, extra, found, lat);
      chk($sformatf("v%0d result_seen", id), 32'(found), 32'd1);
      if (found) begin
         chk_range($sformatf("v%0d latency", id), lat, v.lat_min, v.lat_max);
         chk($sformatf("v%0d medianIndex", id), get_med(v.sel), 32'(v.exp_med));
         chk($sformatf("v%0d totalCount", id), get_tot(v.sel), 32'(v.exp_tot));
         chk($sformatf("v%0d emptyFrame", id), 32'(get_emp(v.sel)), 32'(v.exp_emp));
         chk($sformatf("v%0d busy_in_done", id), 32'(get_busy(v.sel)), 32'd1);
         @(posedge clk); #1;
         chk($sformatf("v%0d pulse_single", id), 32'(get_mv(v.sel)), 32'd0);
         chk($sformatf("v%0d busy_released", id), 32'(get_busy(v.sel)), 32'd0);
         chk($sformatf("v%0d median_held", id), get_med(v.sel), 32'(v.exp_med));
      end
   endtask

   initial begin
      int pulses;
      n_checks = 0;
      n_errors = 0;
      bin_a = '0; vld_a = 1'b0;
      bin_b = '0; vld_b = 1'b0;
      reset = 1'b1;

      //                sel fill s0i s0v s1i  s1v gaps med  tot    emp lmin lmax
      vecs[0] = mk(0,   1,  -1,  0,  -1,  0, 0,  119,   240, 0, 3, 243);
      vecs[1] = mk(0,   0,  -1,  0,  -1,  0, 0,    0,     0, 1, 3,   3);
      vecs[2] = mk(0,   0,   0, 10, 239, 10, 1,    0,    20, 0, 3, 243);
      vecs[3] = mk(0,   0,  37,  5,  -1,  0, 0,   37,     5, 0, 3, 243);
      vecs[4] = mk(0, 180,  -1,  0,  -1,  0, 0,  119, 43200, 0, 3, 243);
      vecs[5] = mk(1, 240,  -1,  0,  -1,  0, 0,   89, 43200, 0, 3, 183);
      vecs[6] = mk(0, 255,  -1,  0,  -1,  0, 0,  119, 61200, 0, 3, 243);
      vecs[7] = mk(1,   0, 179,  1,  -1,  0, 1,  179,     1, 0, 3, 183);

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rst medianIndex", 32'(med_a), 32'd0);
      chk("rst totalCount", 32'(tot_a), 32'd0);
      chk("rst emptyFrame", 32'(emp_a), 32'd0);
      chk("rst medianValid", 32'(mv_a), 32'd0);
      chk("rst busy", 32'(busy_a), 32'd0);
      chk("rst dropError", 32'(drop_a), 32'd0);
      chk("rst state", 32'(st_a), 32'd0);
      chk("rst y busy", 32'(busy_b), 32'd0);
      chk("rst y state", 32'(st_b), 32'd0);

      for (int i = 0; i < 8; i++) begin
         run_vector(vecs[i], 0, i);
         chk($sformatf("v%0d no_drop", i), 32'(get_drop(vecs[i].sel)), 32'd0);
      end

      // Three stray bins right after the last bin land in SCAN and must be dropped.
      run_vector(vecs[0], 3, 100);
      chk("drop flagged", 32'(drop_a), 32'd1);
      run_vector(vecs[1], 0, 101);
      chk("drop sticky", 32'(drop_a), 32'd1);

      // Abort a frame after 100 bins; no result may appear.
      send_frame(vecs[0], 100, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #1;
         if (mv_a) pulses++;
      end
      chk("abort no_pulse", 32'(pulses), 32'd0);
      chk("abort medianIndex", 32'(med_a), 32'd0);
      chk("abort totalCount", 32'(tot_a), 32'd0);
      chk("abort emptyFrame", 32'(emp_a), 32'd0);
      chk("abort dropError", 32'(drop_a), 32'd0);
      chk("abort busy", 32'(busy_a), 32'd0);
      chk("abort state", 32'(st_a), 32'd0);
      run_vector(vecs[0], 0, 102);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
